apb_master_arbiter: RTL and testbench



---
 rtl/apb_arb_pkg.sv | 49 ++++
 rtl/apb_rr_arbiter.sv | 39 +++
 rtl/apb_master_arbiter.sv | 118 +++++++++++
 tb/tb_apb_master_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and round-robin helper for the APB master arbiter.
// Address/data widths default to 32 unless the build defines them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_arb_pkg;

   localparam int MAX_REQ = 16;
   localparam int IDX_W   = 4;
   localparam int DATA_W  = `DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              slverr;
      logic              timeout;
   } rsp_t;

   // First set bit of req scanning last+1, last+2, ... modulo n.
   function automatic logic [MAX_REQ-1:0] rr_next(
      input logic [MAX_REQ-1:0] req,
      input logic [IDX_W-1:0]   last,
      input int unsigned        n
   );
      logic [MAX_REQ-1:0] g;
      logic               found;
      int unsigned        k;
      g     = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= MAX_REQ; i++) begin
         k = (32'(last) + i) % n;
         if (i <= n && !found && req[k[IDX_W-1:0]]) begin
            g[k[IDX_W-1:0]] = 1'b1;
            found           = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin grant selector; owns the last-granted pointer.
import apb_arb_pkg::*;

module apb_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       enable,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] idx
);

   logic [IDX_W-1:0]   rr_last;
   logic [IDX_W-1:0]   idx_full;
   logic [MAX_REQ-1:0] full;

   always_comb begin
      full     = rr_next(MAX_REQ'(req), rr_last, NUM_REQ);
      idx_full = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (full[i]) idx_full = i[IDX_W-1:0];
      end
   end

   assign grant = enable ? full[NUM_REQ-1:0] : '0;
   assign idx   = idx_full[$clog2(NUM_REQ)-1:0];

   // Reset points at the last requester so requester 0 wins first.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         rr_last <= IDX_W'(NUM_REQ - 1);
      end else if (enable && |req) begin
         rr_last <= idx_full;
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant,
// SETUP/ACCESS sequencing, response return and PREADY timeout.
import apb_arb_pkg::*;

module apb_master_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int TIMEOUT    = 16
) (
   input  logic                          PCLK,
   input  logic                          PRESET,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_slverr,
   output logic                          rsp_timeout,
   output logic                          PSEL,
   output logic                          PENABLE,
   output logic                          PWRITE,
   output logic [ADDR_WIDTH-1:0]         PADDR,
   output logic [DATA_WIDTH-1:0]         PWDATA,
   input  logic                          PREADY,
   input  logic                          PSLVERR,
   input  logic [DATA_WIDTH-1:0]         PRDATA
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t          state;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   rsp_t            rsp;
   logic            idle;

   // Keep req_ready low while reset is held so every output reads 0.
   assign idle = (state == IDLE) && !PRESET;

   apb_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .req    (req_valid),
      .enable (idle),
      .grant  (req_ready),
      .idx    (idx)
   );

   assign rsp_rdata   = DATA_WIDTH'(rsp.rdata);
   assign rsp_slverr  = rsp.slverr;
   assign rsp_timeout = rsp.timeout;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state     <= IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         owner     <= '0;
         cnt       <= '0;
         rsp_valid <= '0;
         rsp       <= '0;
      end else begin
         rsp_valid <= '0;
         unique case (state)
            IDLE: begin
               if (|req_valid) begin
                  owner  <= idx;
                  PWRITE <= req_write[idx];
                  PADDR  <= req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                  PWDATA <= req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
                  cnt    <= '0;
                  PSEL   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  state     <= IDLE;
                  rsp_valid <= NUM_REQ'(1) << owner;
                  rsp       <= '{
                     rdata:   PWRITE ? '0 : DATA_W'(PRDATA),
                     slverr:  PSLVERR,
                     timeout: 1'b0
                  };
               end else if (cnt >= CW'(TIMEOUT - 1)) begin
                  // This low cycle is the TIMEOUT-th; force termination.
                  cnt       <= CW'(TIMEOUT);
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  state     <= IDLE;
                  rsp_valid <= NUM_REQ'(1) << owner;
                  rsp       <= '{rdata: '0, slverr: 1'b1, timeout: 1'b1};
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a cycle-level reference model.
module tb_apb_master_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic            PCLK = 1'b0;
   logic            PRESET;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_write = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_slverr;
   logic            rsp_timeout;
   logic            PSEL;
   logic            PENABLE;
   logic            PWRITE;
   logic [AW-1:0]   PADDR;
   logic [DW-1:0]   PWDATA;
   logic            PREADY = 1'b1;
   logic            PSLVERR = 1'b0;
   logic [DW-1:0]   PRDATA = '0;

   int checks = 0;
   int errors = 0;

   apb_master_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR),
      .PRDATA      (PRDATA)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int i = 1; i <= N; i++) begin
         if (v[(last + i) % N]) return (last + i) % N;
      end
      return -1;
   endfunction

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference model: transaction age since accept, low-PREADY count.
   bit            m_busy = 0;
   int            m_age = 0;
   int            m_low = 0;
   int            m_owner = 0;
   int            m_last = N - 1;
   int            m_gnt;
   logic [N-1:0]  e_valid = '0;
   logic [DW-1:0] e_rdata = '0;
   bit            e_err = 0;
   bit            e_to = 0;
   bit            e_wr = 0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wd = '0;

   always_comb m_gnt = rr_pick(req_valid, m_last);

   always @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         m_busy  <= 0;
         m_age   <= 0;
         m_low   <= 0;
         m_owner <= 0;
         m_last  <= N - 1;
         e_valid <= '0;
         e_rdata <= '0;
         e_err   <= 0;
         e_to    <= 0;
         e_wr    <= 0;
         e_addr  <= '0;
         e_wd    <= '0;
      end else begin
         e_valid <= '0;
         if (!m_busy) begin
            if (req_valid != 0) begin
               m_last  <= m_gnt;
               m_owner <= m_gnt;
               e_wr    <= req_write[m_gnt];
               e_addr  <= req_addr[m_gnt*AW +: AW];
               e_wd    <= req_wdata[m_gnt*DW +: DW];
               m_busy  <= 1;
               m_age   <= 1;
               m_low   <= 0;
            end
         end else if (m_age == 1) begin
            m_age <= 2;
         end else if (PREADY) begin
            e_valid <= N'(1) << m_owner;
            e_rdata <= e_wr ? '0 : PRDATA;
            e_err   <= PSLVERR;
            e_to    <= 0;
            m_busy  <= 0;
         end else if (m_low + 1 >= TO) begin
            e_valid <= N'(1) << m_owner;
            e_rdata <= '0;
            e_err   <= 1;
            e_to    <= 1;
            m_busy  <= 0;
         end else begin
            m_low <= m_low + 1;
         end
      end
   end

   always @(negedge PCLK) begin
      logic [N-1:0] exp_ready;
      exp_ready = (!PRESET && !m_busy && req_valid != 0)
                  ? N'(1) << m_gnt : '0;
      chk("req_ready", req_ready, exp_ready);
      chk("PSEL", PSEL, m_busy);
      chk("PENABLE", PENABLE, m_busy && m_age == 2);
      chk("PWRITE", PWRITE, e_wr);
      chk("PADDR", PADDR, e_addr);
      chk("PWDATA", PWDATA, e_wd);
      chk("rsp_valid", rsp_valid, e_valid);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_slverr", rsp_slverr, e_err);
      chk("rsp_timeout", rsp_timeout, e_to);
   end

   task automatic tick();
      @(posedge PCLK);
      #2;
   endtask

   task automatic idle_wait();
      for (int c = 0; c < 40 && PSEL; c++) tick();
      chk("idle_wait", PSEL, 1'b0);
   endtask

   task automatic set_req(input int i, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]         = wr;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int gi[$];
      int gc[$];
      int n;

      PRESET = 1'b1;
      repeat (3) @(posedge PCLK);
      #2 PRESET = 1'b0;
      #1;
      chk("reset PSEL", PSEL, 1'b0);
      chk("reset rsp_valid", rsp_valid, '0);
      chk("reset PADDR", PADDR, '0);

      // Zero-wait read by requester 0.
      set_req(0, 0, 32'h10, 32'h0);
      PRDATA    = 32'hA5A5_0001;
      PREADY    = 1'b1;
      req_valid = 4'b0001;
      #1 chk("t1 ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      chk("t1 setup PSEL", PSEL, 1'b1);
      chk("t1 setup PENABLE", PENABLE, 1'b0);
      chk("t1 PADDR", PADDR, 32'h10);
      tick();
      chk("t1 access PENABLE", PENABLE, 1'b1);
      tick();
      chk("t1 rsp_valid", rsp_valid, 4'b0001);
      chk("t1 rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("t1 rsp_slverr", rsp_slverr, 1'b0);
      chk("t1 PSEL off", PSEL, 1'b0);

      // Write by requester 2 with two wait states.
      set_req(2, 1, 32'h24, 32'hDEAD_BEEF);
      PRDATA    = 32'h0BAD_F00D;
      PREADY    = 1'b0;
      req_valid = 4'b0100;
      #1 chk("t2 ready", req_ready, 4'b0100);
      for (int c = 1; c <= 4; c++) begin
         tick();
         req_valid = '0;
         if (c == 4) PREADY = 1'b1;
         chk("t2 PADDR", PADDR, 32'h24);
         chk("t2 PWDATA", PWDATA, 32'hDEAD_BEEF);
         chk("t2 PWRITE", PWRITE, 1'b1);
         chk("t2 PENABLE", PENABLE, c >= 2);
      end
      tick();
      chk("t2 rsp_valid", rsp_valid, 4'b0100);
      chk("t2 rsp_rdata", rsp_rdata, 32'h0);

      // All requesters valid from reset: fair rotation, 3-cycle spacing.
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 0, AW'(32'h100 + i * 4), '0);
      PRDATA    = 32'h1111_2222;
      PREADY    = 1'b1;
      req_valid = 4'b1111;
      for (int c = 0; c < 40 && gi.size() < 5; c++) begin
         #1;
         if (req_ready != 0) begin
            gi.push_back(oh_idx(req_ready));
            gc.push_back(c);
         end
         tick();
      end
      req_valid = '0;
      chk("t3 grant count", 64'(gi.size()), 64'd5);
      for (int k = 0; k < gi.size(); k++) begin
         chk("t3 grant order", 64'(gi[k]), 64'(k % N));
         if (k > 0) chk("t3 spacing", 64'(gc[k] - gc[k-1]), 64'd3);
      end
      idle_wait();

      // Timeout on requester 1, then a normal read by requester 3.
      set_req(1, 0, 32'h40, '0);
      PRDATA    = 32'h5555_5555;
      PREADY    = 1'b0;
      req_valid = 4'b0010;
      #1 chk("t4 ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      tick();
      n = 0;
      while (PENABLE === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk("t4 access cycles", 64'(n), 64'(TO));
      chk("t4 PSEL off", PSEL, 1'b0);
      chk("t4 rsp_valid", rsp_valid, 4'b0010);
      chk("t4 rsp_slverr", rsp_slverr, 1'b1);
      chk("t4 rsp_timeout", rsp_timeout, 1'b1);
      chk("t4 rsp_rdata", rsp_rdata, 32'h0);
      set_req(3, 0, 32'h3C, '0);
      PRDATA    = 32'h1234_5678;
      PREADY    = 1'b1;
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      tick();
      chk("t4b rsp_valid", rsp_valid, 4'b1000);
      chk("t4b rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk("t4b rsp_timeout", rsp_timeout, 1'b0);

      // Slave error on a read by requester 0.
      PSLVERR   = 1'b1;
      PRDATA    = 32'hCAFE_0005;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      tick();
      PSLVERR = 1'b0;
      chk("t5 rsp_valid", rsp_valid, 4'b0001);
      chk("t5 rsp_slverr", rsp_slverr, 1'b1);
      chk("t5 rsp_timeout", rsp_timeout, 1'b0);
      chk("t5 rsp_rdata", rsp_rdata, 32'hCAFE_0005);

      // Reset during ACCESS of requester 1.
      PREADY    = 1'b0;
      req_valid = 4'b0010;
      #1 chk("t6 ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      tick();
      chk("t6 in access", PENABLE, 1'b1);
      PRESET = 1'b1;
      #1;
      chk("t6 PSEL async", PSEL, 1'b0);
      chk("t6 PENABLE async", PENABLE, 1'b0);
      req_valid = 4'b0011;
      tick();
      tick();
      chk("t6 no rsp", rsp_valid, '0);
      chk("t6 ready in reset", req_ready, '0);
      PRESET = 1'b0;
      #1 chk("t6 ready after", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      PREADY    = 1'b1;
      idle_wait();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
